// File: rtl/key_press_counter.sv
// PS/2 scan-code decoder that tracks the last pressed key and counts presses (wrapping at COUNT_MAX).
// Optional macro KEYCNT_REPEAT_FILTER_EN: when defined, typematic repeats of the held key are not counted.
module key_press_counter #(
  parameter int unsigned COUNT_MAX = 99
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_down,
  output logic [7:0] press_cnt,
  output logic       cnt_pulse
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0] C_MAX    = COUNT_MAX[7:0];
  localparam logic [7:0] C_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] C_PREFIX_BRK = 8'hF0;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_key_code;
  logic       r_key_ext;
  logic       r_key_down;
  logic [7:0] r_press_cnt;
  logic       r_cnt_pulse;

  logic       w_make;
  logic       w_brk;
  logic       w_ext;
  logic       w_match;
  logic       w_new_press;
  logic       w_repeat;
  logic       w_count;
  logic [7:0] w_cnt_inc;

  // Decoder state register; reset drops any pending prefix.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Prefix decoding: classify each valid byte as prefix, make or break.
  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    w_ext       = 1'b0;
    if (in_valid) begin
      case (r_state)
        S_IDLE: begin
          if (in_data == C_PREFIX_EXT) begin
            w_state_nxt = S_EXT;
          end else if (in_data == C_PREFIX_BRK) begin
            w_state_nxt = S_BRK;
          end else begin
            w_make = 1'b1;
          end
        end
        S_EXT: begin
          if (in_data == C_PREFIX_BRK) begin
            w_state_nxt = S_EXT_BRK;
          end else if (in_data == C_PREFIX_EXT) begin
            w_state_nxt = S_EXT;
          end else begin
            w_make      = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          if (in_data == C_PREFIX_EXT) begin
            w_state_nxt = S_EXT;
          end else if (in_data == C_PREFIX_BRK) begin
            w_state_nxt = S_BRK;
          end else begin
            w_brk       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (in_data == C_PREFIX_EXT) begin
            w_state_nxt = S_EXT;
          end else if (in_data == C_PREFIX_BRK) begin
            w_state_nxt = S_EXT_BRK;
          end else begin
            w_brk       = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Press classification against the currently tracked key.
  always_comb begin
    w_match     = ({w_ext, in_data} == {r_key_ext, r_key_code});
    w_new_press = w_make && (!r_key_down || !w_match);
    w_repeat    = w_make && r_key_down && w_match;
`ifdef KEYCNT_REPEAT_FILTER_EN
    w_count     = w_new_press;
`else
    w_count     = w_new_press || w_repeat;
`endif
    if (r_press_cnt >= C_MAX) begin
      w_cnt_inc = 8'd0;
    end else begin
      w_cnt_inc = r_press_cnt + 8'd1;
    end
  end

  // Registered key tracking, press counter and count strobe.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_key_code  <= 8'd0;
      r_key_ext   <= 1'b0;
      r_key_down  <= 1'b0;
      r_press_cnt <= 8'd0;
      r_cnt_pulse <= 1'b0;
    end else begin
      r_cnt_pulse <= w_count;
      if (w_count) begin
        r_key_code  <= in_data;
        r_key_ext   <= w_ext;
        r_key_down  <= 1'b1;
        r_press_cnt <= w_cnt_inc;
      end else if (w_brk && w_match && r_key_down) begin
        r_key_down  <= 1'b0;
      end
    end
  end

  assign key_code  = r_key_code;
  assign key_ext   = r_key_ext;
  assign key_down  = r_key_down;
  assign press_cnt = r_press_cnt;
  assign cnt_pulse = r_cnt_pulse;

endmodule
